// File: rtl/instr_sequencer_pkg.sv
// Shared types and instruction field map for the instruction sequencer.
// Instruction word: op[23:22] alu[21:20] wa[19:16] ra1[15:12] ra2[11:8] imm[7:0].
package instr_sequencer_pkg;

   localparam int OP_LSB  = 22;
   localparam int ALU_LSB = 20;
   localparam int WA_LSB  = 16;
   localparam int RA1_LSB = 12;
   localparam int RA2_LSB = 8;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      OP_ALU_REG  = 2'b00,
      OP_LOAD_IMM = 2'b01,
      OP_NOP      = 2'b10,
      OP_HALT     = 2'b11
   } op_t;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE   = 2'd0;
   localparam state_t S_FETCH  = 2'd1;
   localparam state_t S_EXEC   = 2'd2;
   localparam state_t S_HALTED = 2'd3;

   function automatic op_t op_of(input logic [23:0] w);
      return op_t'(w[OP_LSB +: 2]);
   endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program store: synchronous write, asynchronous read, contents not reset.
module instr_sequencer_mem #(
   parameter int PC_W = 4,
   parameter int IW   = 24
) (
   input  logic            clk,
   input  logic            we,
   input  logic [PC_W-1:0] waddr,
   input  logic [IW-1:0]   wdata,
   input  logic [PC_W-1:0] raddr,
   output logic [IW-1:0]   rdata
);

   logic [IW-1:0] mem [2**PC_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps a PC through a loadable program, one instruction per FETCH/EXEC pair,
// and drives register-file/ALU datapath controls until a HALT is executed.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int PC_W = 4,
   parameter int RA_W = 4,
   parameter int DW   = 8,
   parameter int IW   = 24
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            prog_we,
   input  logic [PC_W-1:0] prog_addr,
   input  logic [IW-1:0]   prog_data,
   output logic [RA_W-1:0] RA1,
   output logic [RA_W-1:0] RA2,
   output logic [RA_W-1:0] WA,
   output logic [DW-1:0]   external_data_in,
   output logic [1:0]      ALUcontrol,
   output logic            ALUsrc,
   output logic            regwrite,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted
);

   state_t        state;
   logic [IW-1:0] ir;
   logic [IW-1:0] word;
   logic          mem_we;
   op_t           fop;
   op_t           xop;
   logic          unused_ir;

   assign busy   = (state == S_FETCH) || (state == S_EXEC);
   assign halted = (state == S_HALTED);
   assign mem_we = prog_we && !busy;

   assign fop = op_of(word);
   assign xop = op_of(ir);

   // only the opcode is needed once the controls are latched at fetch
   assign unused_ir = ^ir[OP_LSB-1:0];

   instr_sequencer_mem #(
      .PC_W (PC_W),
      .IW   (IW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc),
      .rdata (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         pc               <= '0;
         ir               <= '0;
         RA1              <= '0;
         RA2              <= '0;
         WA               <= '0;
         external_data_in <= '0;
         ALUcontrol       <= '0;
         ALUsrc           <= 1'b0;
         regwrite         <= 1'b0;
      end else begin
         regwrite <= 1'b0;
         unique case (state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  state <= S_FETCH;
                  pc    <= '0;
               end
            end
            S_FETCH: begin
               // controls load on this edge so they are valid all of EXEC
               ir    <= word;
               state <= S_EXEC;
               unique case (fop)
                  OP_ALU_REG: begin
                     RA1        <= word[RA1_LSB +: RA_W];
                     RA2        <= word[RA2_LSB +: RA_W];
                     WA         <= word[WA_LSB +: RA_W];
                     ALUcontrol <= word[ALU_LSB +: 2];
                     ALUsrc     <= 1'b0;
                     regwrite   <= 1'b1;
                  end
                  OP_LOAD_IMM: begin
                     WA               <= word[WA_LSB +: RA_W];
                     external_data_in <= word[IMM_LSB +: DW];
                     ALUcontrol       <= word[ALU_LSB +: 2];
                     ALUsrc           <= 1'b1;
                     regwrite         <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_EXEC: begin
               if (xop == OP_HALT) begin
                  state <= S_HALTED;
               end else begin
                  pc    <= pc + PC_W'(1);
                  state <= S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
